// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - ALU op codes, FSM state encodings and width constants
`timescale 1ns/1ps
package alu_exec_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_alu_comb.sv
// rtl/alu_exec_unit_alu_comb.sv - combinational single-cycle ALU datapath (add/sub/logic/compare)
`timescale 1ns/1ps
module alu_comb
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        case (alu_op)
            ALU_ADD:  y = src_a + src_b;
            ALU_SUB:  y = src_a - src_b;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_XOR:  y = src_a ^ src_b;
            ALU_OR:   y = src_a | src_b;
            ALU_AND:  y = src_a & src_b;
            // shifts are handled iteratively by the top; illegal codes give 0
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with iterative 1-bit-per-cycle shifter and valid/ready handshake
`timescale 1ns/1ps
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    state_t               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [XLEN-1:0]      result_q, result_d;
    logic                 zero_q, zero_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]      comb_y;
    logic [SHAMT_W-1:0]   shamt;

    assign shamt = src_b[SHAMT_W-1:0];

    alu_comb #(.XLEN(XLEN)) u_alu_comb (
        .alu_op (alu_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .y      (comb_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= ALU_ADD;
            result_q <= '0;
            zero_q   <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = alu_op;
                    if (is_shift(alu_op)) begin
                        result_d = src_a;
                        if (shamt == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = shamt;
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        result_d = comb_y;
                        state_d  = ST_DONE;
                    end
                    zero_d = (result_d == '0);
                end
            end
            ST_SHIFT: begin
                case (op_q)
                    ALU_SLL: result_d = {result_q[XLEN-2:0], 1'b0};
                    ALU_SRL: result_d = {1'b0, result_q[XLEN-1:1]};
                    default: result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
                endcase
                cnt_d  = cnt_q - SHAMT_W'(1);
                zero_d = (result_d == '0);
                // the shift performed while the counter reads 1 is the last one
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
`timescale 1ns/1ps
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int tests;
    int failed;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        src_a    = a;
        src_b    = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src_a    = 32'hDEAD_BEEF;
        src_b    = 32'hDEAD_BEEF;
        alu_op   = 4'd0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_zero, input int exp_lat);
        int  lat;
        logic busy_ready;
        busy_ready = 1'b0;
        issue(op, a, b);
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_zero});
        chk({tag, "_busy_in_ready"}, {31'b0, busy_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ret_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 4'd0;
        src_a     = '0;
        src_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("add", 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
        run_op("sub_neg", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("sub_zero", 4'd1, 32'd9, 32'd9, 32'd0, 1'b1, 1);
        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
        run_op("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        run_op("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
        run_op("xor", 4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1);
        run_op("or", 4'd8, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0, 1);
        run_op("and", 4'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1);
        run_op("illegal", 4'd12, 32'd5, 32'd7, 32'd0, 1'b1, 1);
        run_op("sra4", 4'd7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 5);
        run_op("sll0", 4'd2, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 1);
        run_op("srl3", 4'd6, 32'h8000_0010, 32'h0000_0003, 32'h1000_0002, 1'b0, 4);
        run_op("sll31", 4'd2, 32'h0000_0003, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32);
        run_op("srl_out", 4'd6, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 2);

        // backpressure: result held, second request ignored, no accept in DONE
        issue(4'd0, 32'd1, 32'd2);
        in_valid = 1'b1;
        alu_op   = 4'd1;
        src_a    = 32'd100;
        src_b    = 32'd1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", result, 32'd3);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_ret_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_ret_out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_ret_result", result, 32'd3);

        // asynchronous reset in the middle of a shift
        issue(4'd2, 32'd1, 32'd10);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rs_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rs_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rs_result", result, 32'd0);
        chk("rs_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("rs_no_result", {31'b0, out_valid}, 32'd0);
        end

        run_op("post_rst_add", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
